pixel_demux_packer: RTL and testbench
=====================================

Name: pixel_demux_packer

Overview:
Write-side counterpart of the pixel select mux. It accepts a stream of OUT_SIZE-bit pixel words through a valid/ready handshake and writes them in order into SEL_SIZE slots. When all slots are filled, it presents the whole packed bus downstream as one frame. The slot layout matches the mux's select indexing, so a packed frame can be read back slot-by-slot by the existing pixel mux.

Parameters:
OUT_SIZE, 70, width of one pixel slot in bits
SEL_SIZE, 112, number of slots per frame
SEL_BIT, 7, slot index width; must satisfy 2**SEL_BIT >= SEL_SIZE

Ports:
Clk  input  1  single clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
In_Data  input  OUT_SIZE  pixel word to write
In_Valid  input  1  In_Data valid this cycle
In_Ready  output  1  block can accept a word this cycle
In_Abort  input  1  discard the partially filled frame
Out  output  OUT_SIZE*SEL_SIZE  packed frame; slot k at Out[OUT_SIZE*(k+1)-1 : OUT_SIZE*k]
Out_Valid  output  1  Out holds a complete frame
Out_Ready  input  1  downstream consumes the frame
Count  output  SEL_BIT  index of the next slot to be written

Behaviour:
- Reset (Reset=1 at a rising edge): Out=0, Out_Valid=0, In_Ready=1, Count=0, state=FILL. Reset has priority over every other input. Reset mid-frame discards all partial data.
- States: FILL (In_Ready=1, Out_Valid=0) and FULL (In_Ready=0, Out_Valid=1). Both outputs are registered and decoded directly from state; they have no combinational path from inputs.
- Accept = In_Valid & In_Ready.
- FILL on Accept:
  - slot[Count] <= In_Data; no other slot changes.
  - If Count < SEL_SIZE-1: Count <= Count+1.
  - If Count == SEL_SIZE-1: Count <= 0 and state <= FULL. Out_Valid rises on the cycle after the final accept (latency 1).
- FILL, In_Valid=0: hold all state.
- FULL: Out is stable and In_Data is ignored.
  - On Out_Ready=1: state <= FILL, so Out_Valid falls and In_Ready rises on the next cycle.
  - Out_Ready=0: hold indefinitely.
- Slot contents are never cleared except by Reset. In the next frame, each slot keeps its old value until it is overwritten. Consumers may sample Out only while Out_Valid=1.
- In_Abort in FILL: Count <= 0, stay in FILL, and do not write slot data. If In_Abort coincides with Accept, the abort wins and the word is dropped. In_Abort in FULL is ignored; a completed frame is never discarded.
- Simultaneous events:
  - In FULL, In_Valid=1 together with Out_Ready=1: the word is not accepted (In_Ready=0 that cycle). The first accept can occur on the following cycle.
  - Maximum throughput is one frame per SEL_SIZE+1 cycles.
- Count never exceeds SEL_SIZE-1. Indices SEL_SIZE..2**SEL_BIT-1 are unreachable, and no write occurs to them.
- No arithmetic on pixel data: words are stored bit-exact with no sign or width conversion.

Decomposition:
- Shared package:
  - OUT_SIZE/SEL_SIZE/SEL_BIT defaults, shared with the pixel mux.
  - State encoding: FILL=1'b0, FULL=1'b1.
  - A slot-slice helper (offset = k*OUT_SIZE).
- One natural sub-module, pixel_slot_decoder: combinational, Count + write-enable -> SEL_SIZE one-hot slot enables. The top level holds the counter, FSM and slot registers.

Test Plan:
- Reset then stream 0..111 (In_Data=k for slot k, In_Valid held 1) -> In_Ready=1 for 112 cycles; Out_Valid=1 on cycle 113; slot k == k for all k; Count=0.
- Hold Out_Ready=0 for 20 cycles in FULL while In_Valid=1 with In_Data=70'h3FF -> Out unchanged, In_Ready=0. Then pulse Out_Ready -> next cycle Out_Valid=0, In_Ready=1.
- Gappy input: In_Valid toggling randomly, 112 accepts -> frame complete exactly after the 112th accept; no duplicated or skipped slots.
- Write 50 words, assert In_Abort together with In_Valid (data 70'h1) -> Count=0, word dropped; then 112 new words -> slots 0..111 hold the new data only.
- Reset asserted after 60 accepts -> Out=0, Count=0, Out_Valid=0 next cycle; a following full frame completes normally.
- Two back-to-back frames with Out_Ready tied 1 -> Out_Valid high exactly 1 cycle per frame, 113-cycle period; frame 2 data (All-ones slots) fully replaces frame 1.

Source files
------------

// File: rtl/pixel_demux_packer_pkg.sv
// Shared geometry, state encoding and slot-slice helper for the pixel mux/demux pair.
// Packing only: no latency or backpressure behaviour lives here.
package pixel_demux_packer_pkg;

  localparam int OUT_SIZE = 70;
  localparam int SEL_SIZE = 112;
  localparam int SEL_BIT  = 7;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  // Bit offset of slot k inside the packed frame, identical to the mux select indexing.
  function automatic int slot_lo(input int k);
    return k * OUT_SIZE;
  endfunction

endpackage

// File: rtl/pixel_demux_packer_if.sv
// Pixel-in / frame-out bundle; master drives words and frame ready, slave is the packer.
// Pure wiring: no latency; backpressure is In_Ready / Out_Ready.
interface pixel_demux_packer_if;
  import pixel_demux_packer_pkg::*;

  logic [OUT_SIZE-1:0]          In_Data;
  logic                         In_Valid;
  logic                         In_Ready;
  logic                         In_Abort;
  logic [OUT_SIZE*SEL_SIZE-1:0] Out;
  logic                         Out_Valid;
  logic                         Out_Ready;
  logic [SEL_BIT-1:0]           Count;

  modport master (
    output In_Data, In_Valid, In_Abort, Out_Ready,
    input  In_Ready, Out, Out_Valid, Count
  );

  modport slave (
    input  In_Data, In_Valid, In_Abort, Out_Ready,
    output In_Ready, Out, Out_Valid, Count
  );

endinterface

// File: rtl/pixel_slot_decoder.sv
// Count + write enable to one-hot slot enables; combinational, no backpressure.
// Out-of-range counts decode to no enable at all.
module pixel_slot_decoder
  import pixel_demux_packer_pkg::*;
(
  input  logic [SEL_BIT-1:0]  count,
  input  logic                wr_en,
  output logic [SEL_SIZE-1:0] slot_en
);

  always_comb begin
    slot_en = '0;
    for (int k = 0; k < SEL_SIZE; k++) begin
      if (wr_en && (count == SEL_BIT'(k))) begin
        slot_en[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_demux_packer.sv
// Packs SEL_SIZE pixel words into one frame; Out_Valid rises 1 cycle after the last accept.
// In_Ready drops while a frame waits in FULL; the frame is held until Out_Ready.
module pixel_demux_packer
  import pixel_demux_packer_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  pixel_demux_packer_if.slave  bus
);

  localparam logic [SEL_BIT-1:0] LAST = SEL_BIT'(SEL_SIZE - 1);

  state_t              state, state_nxt;
  logic [SEL_BIT-1:0]  count, count_nxt;
  logic                wr_en;
  logic [SEL_SIZE-1:0] slot_en;
  logic [OUT_SIZE-1:0] slots [SEL_SIZE];

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    wr_en     = 1'b0;
    case (state)
      FILL: begin
        // Abort outranks a coincident accept: the word is dropped, not written.
        if (bus.In_Abort) begin
          count_nxt = '0;
        end else if (bus.In_Valid) begin
          wr_en = 1'b1;
          if (count == LAST) begin
            count_nxt = '0;
            state_nxt = FULL;
          end else begin
            count_nxt = count + SEL_BIT'(1);
          end
        end
      end
      FULL: begin
        if (bus.Out_Ready) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  pixel_slot_decoder u_dec (
    .count   (count),
    .wr_en   (wr_en),
    .slot_en (slot_en)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= FILL;
      count <= '0;
      for (int k = 0; k < SEL_SIZE; k++) begin
        slots[k] <= '0;
      end
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      for (int k = 0; k < SEL_SIZE; k++) begin
        if (slot_en[k]) begin
          slots[k] <= bus.In_Data;
        end
      end
    end
  end

  for (genvar k = 0; k < SEL_SIZE; k++) begin : g_out
    localparam int LO = slot_lo(k);
    assign bus.Out[LO +: OUT_SIZE] = slots[k];
  end

  assign bus.In_Ready  = (state == FILL);
  assign bus.Out_Valid = (state == FULL);
  assign bus.Count     = count;

endmodule

// File: tb/tb_pixel_demux_packer.sv
// Directed bench for pixel_demux_packer: driver pushes expected frames into a queue,
// a negedge monitor pops and compares on every Out_Valid & Out_Ready handshake.
module tb_pixel_demux_packer;
  import pixel_demux_packer_pkg::*;

  typedef logic [OUT_SIZE*SEL_SIZE-1:0] frame_t;

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   check_period = 1'b0;

  logic [OUT_SIZE-1:0] exp_slots [SEL_SIZE];
  int                  exp_count = 0;
  frame_t              sb [$];

  pixel_demux_packer_if bus ();

  pixel_demux_packer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_frame(input string name, input frame_t act, input frame_t exp);
    checks++;
    if (act !== exp) begin
      int bad = -1;
      failures++;
      for (int k = SEL_SIZE - 1; k >= 0; k--) begin
        if (act[k*OUT_SIZE +: OUT_SIZE] !== exp[k*OUT_SIZE +: OUT_SIZE]) bad = k;
      end
      $display("FAIL %s slot %0d got %0h want %0h", name, bad,
               act[bad*OUT_SIZE +: OUT_SIZE], exp[bad*OUT_SIZE +: OUT_SIZE]);
    end
  endtask

  function automatic frame_t model_frame();
    frame_t f;
    for (int k = 0; k < SEL_SIZE; k++) f[k*OUT_SIZE +: OUT_SIZE] = exp_slots[k];
    return f;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < SEL_SIZE; k++) exp_slots[k] = '0;
    exp_count = 0;
  endtask

  task automatic model_accept(input logic [OUT_SIZE-1:0] d);
    exp_slots[exp_count] = d;
    if (exp_count == SEL_SIZE - 1) begin
      exp_count = 0;
      sb.push_back(model_frame());
    end else begin
      exp_count++;
    end
  endtask

  // Presents d with In_Valid=1 and returns after the accepting edge; In_Valid stays high.
  task automatic send(input logic [OUT_SIZE-1:0] d, output int waits);
    waits = 0;
    bus.In_Valid = 1'b1;
    bus.In_Data  = d;
    @(negedge Clk);
    while (!bus.In_Ready && waits < 300) begin
      @(negedge Clk);
      waits++;
    end
    if (!bus.In_Ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got In_Ready=0 want 1");
    end else begin
      model_accept(d);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic release_frame();
    bus.Out_Ready = 1'b1;
    @(posedge Clk);
    #1;
    bus.Out_Ready = 1'b0;
    bus.In_Valid  = 1'b0;
    bus.In_Abort  = 1'b0;
    @(negedge Clk);
    chk("release_out_valid", 128'(bus.Out_Valid), 128'(0));
    chk("release_in_ready", 128'(bus.In_Ready), 128'(1));
    chk("release_count", 128'(bus.Count), 128'(0));
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard monitor.
  int last_pop = 0;
  bit have_prev = 1'b0;
  initial begin
    forever begin
      @(negedge Clk);
      cyc++;
      if (!check_period) have_prev = 1'b0;
      if (Reset === 1'b0 && bus.Out_Valid === 1'b1 && bus.Out_Ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame got frame want none");
        end else begin
          chk_frame("frame", bus.Out, sb.pop_front());
          chk("frame_count", 128'(bus.Count), 128'(0));
          if (check_period && have_prev) chk("frame_period", 128'(cyc - last_pop), 128'(SEL_SIZE + 1));
          last_pop  = cyc;
          have_prev = 1'b1;
        end
      end
    end
  end

  initial begin
    int w;
    int n;
    int iter;
    frame_t zero_f;
    zero_f = '0;
    Reset = 1'b1;
    bus.In_Data = '0;
    bus.In_Valid = 1'b0;
    bus.In_Abort = 1'b0;
    bus.Out_Ready = 1'b0;
    model_clear();
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk_frame("reset_out", bus.Out, zero_f);
    chk("reset_out_valid", 128'(bus.Out_Valid), 128'(0));
    chk("reset_in_ready", 128'(bus.In_Ready), 128'(1));
    chk("reset_count", 128'(bus.Count), 128'(0));
    @(posedge Clk);
    #1;

    // Frame 1: slot k = k, streamed with In_Valid held.
    for (int k = 0; k < SEL_SIZE; k++) begin
      send(OUT_SIZE'(k), w);
      chk("stream_ready", 128'(w), 128'(0));
    end
    // FULL hold with a pending word and abort, both ignored.
    bus.In_Data  = 70'h3FF;
    bus.In_Valid = 1'b1;
    bus.In_Abort = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      chk("hold_out_valid", 128'(bus.Out_Valid), 128'(1));
      chk("hold_in_ready", 128'(bus.In_Ready), 128'(0));
      chk("hold_count", 128'(bus.Count), 128'(0));
      if (sb.size() > 0) chk_frame("hold_out", bus.Out, sb[0]);
      @(posedge Clk);
      #1;
    end
    release_frame();

    // Gappy input.
    n = 0;
    iter = 0;
    while (n < SEL_SIZE && iter < 2000) begin
      logic [OUT_SIZE-1:0] d;
      d = (OUT_SIZE'(n) << 40) | OUT_SIZE'(n + 7);
      bus.In_Valid = ($urandom_range(0, 2) != 0);
      bus.In_Data  = d;
      @(negedge Clk);
      chk("gappy_out_valid", 128'(bus.Out_Valid), 128'(0));
      if (bus.In_Valid) begin
        model_accept(d);
        n++;
      end
      @(posedge Clk);
      #1;
      iter++;
    end
    bus.In_Valid = 1'b0;
    @(negedge Clk);
    chk("gappy_done", 128'(bus.Out_Valid), 128'(1));
    @(posedge Clk);
    #1;
    release_frame();

    // Partial frame, abort with a coincident word, then a fresh frame.
    for (int k = 0; k < 50; k++) send(OUT_SIZE'(k + 'h5000), w);
    bus.In_Valid = 1'b0;
    @(negedge Clk);
    chk("pre_abort_count", 128'(bus.Count), 128'(50));
    @(posedge Clk);
    #1;
    bus.In_Valid = 1'b1;
    bus.In_Data  = 70'h1;
    bus.In_Abort = 1'b1;
    @(posedge Clk);
    #1;
    bus.In_Valid = 1'b0;
    bus.In_Abort = 1'b0;
    exp_count = 0;
    @(negedge Clk);
    chk("abort_count", 128'(bus.Count), 128'(0));
    chk("abort_out_valid", 128'(bus.Out_Valid), 128'(0));
    @(posedge Clk);
    #1;
    for (int k = 0; k < SEL_SIZE; k++) send((OUT_SIZE'(3) << 66) | OUT_SIZE'(k * 9), w);
    bus.In_Valid = 1'b0;
    release_frame();

    // Reset mid-frame.
    for (int k = 0; k < 60; k++) send(OUT_SIZE'(k + 'h777), w);
    bus.In_Valid = 1'b0;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_clear();
    @(negedge Clk);
    chk_frame("midreset_out", bus.Out, zero_f);
    chk("midreset_count", 128'(bus.Count), 128'(0));
    chk("midreset_out_valid", 128'(bus.Out_Valid), 128'(0));
    chk("midreset_in_ready", 128'(bus.In_Ready), 128'(1));
    @(posedge Clk);
    #1;
    for (int k = 0; k < SEL_SIZE; k++) send(OUT_SIZE'(k + 'h1234), w);
    bus.In_Valid = 1'b0;
    release_frame();

    // Back-to-back frames with Out_Ready tied high.
    bus.Out_Ready = 1'b1;
    check_period  = 1'b1;
    for (int k = 0; k < SEL_SIZE; k++) send(OUT_SIZE'(k + 500), w);
    for (int k = 0; k < SEL_SIZE; k++) begin
      send('1, w);
      if (k == 0) chk("b2b_full_gap", 128'(w), 128'(1));
    end
    bus.In_Valid = 1'b0;
    iter = 0;
    while (sb.size() > 0 && iter < 20) begin
      @(negedge Clk);
      iter++;
    end
    repeat (3) @(negedge Clk);
    check_period  = 1'b0;
    bus.Out_Ready = 1'b0;

    chk("leftover_frames", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
